// File: rtl/y86_stage_sequencer.sv
// rtl/y86_stage_sequencer.sv - Y86-64 multi-cycle stage sequencer with status and perf counters
module y86_stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_next;
    logic [2:0] stat_next;
    logic [3:0] icode_q;
    logic [7:0] wait_cnt;
    logic       mem_access;

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    always_comb begin
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_access = 1'b1;
            default:                            mem_access = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        stat_next  = stat;
        case (state)
            S_IDLE:      if (start) state_next = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_next = S_HALT;
                    stat_next  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_next = S_HALT;
                    stat_next  = STAT_HLT;
                end else begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE:   state_next = S_MEMORY;
            S_MEMORY: begin
                if (!mem_access) begin
                    state_next = S_WRITEBACK;
                end else if (mem_ready) begin
                    state_next = dmem_error ? S_HALT : S_WRITEBACK;
                    if (dmem_error) stat_next = STAT_ADR;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_next = S_PCUPD;
            S_PCUPD:     state_next = S_FETCH;
            default:     state_next = S_HALT;
        endcase
    end

    always_comb begin
        fetch_en     = (state == S_FETCH);
        decode_en    = (state == S_DECODE);
        execute_en   = (state == S_EXECUTE);
        memory_en    = (state == S_MEMORY);
        writeback_en = (state == S_WRITEBACK);
        pc_en        = (state == S_PCUPD);
        mem_req      = (state == S_MEMORY) && mem_access;
        busy         = (state != S_IDLE) && (state != S_HALT);
    end

    // wait_cnt counts completed MEMORY cycles; it is zero on the first one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q     <= 4'h0;
            stat        <= STAT_AOK;
            wait_cnt    <= 8'd0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state == S_FETCH) icode_q <= icode;
            stat     <= stat_next;
            wait_cnt <= (state == S_MEMORY) ? wait_cnt + 8'd1 : 8'd0;
            if (busy)             cycle_count <= cycle_count + CNT_W'(1);
            if (state == S_PCUPD) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// tb/tb_y86_stage_sequencer.sv - directed scoreboard bench for y86_stage_sequencer
module tb_y86_stage_sequencer;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n, start, instr_valid, imem_error, mem_ready, dmem_error;
    logic [3:0]  icode;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en, mem_req, busy;
    logic [2:0]  stat;
    logic [31:0] cycle_count, instr_count;

    y86_stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .mem_ready(mem_ready), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memory_en(memory_en), .writeback_en(writeback_en), .pc_en(pc_en),
        .mem_req(mem_req), .stat(stat), .busy(busy),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // bench state numbering: 0 idle, 1..6 F D E M W P, 7 halt
    typedef struct {
        logic [5:0] en;
        logic       mreq;
        logic [2:0] st;
        logic       bsy;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_stat;
    bit         halted;

    task automatic push(input int s, input logic mreq);
        exp_t e;
        e.en   = (s >= 1 && s <= 6) ? (6'b100000 >> (s - 1)) : 6'b000000;
        e.mreq = mreq;
        e.st   = exp_stat;
        e.bsy  = (s >= 1 && s <= 6);
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag);
        exp_t       e;
        logic [10:0] obs, exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e   = sb.pop_front();
        obs = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en, mem_req, stat, busy};
        exp = {e.en, e.mreq, e.st, e.bsy};
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (en6,mreq,stat3,busy)", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    task automatic chk_cnt(input string tag, input int cc, input int ic);
        checks++;
        assert ({cycle_count, instr_count} === {32'(cc), 32'(ic)}) else begin
            errors++;
            $error("FAIL %s counters observed=%0d/%0d expected=%0d/%0d", tag, cycle_count, instr_count, cc, ic);
        end
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        exp_stat = 3'd1;
        push(0, 1'b0);
        check_now(tag);
        chk_cnt(tag, 0, 0);
        #2 rst_n = 1'b1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        push(1, 1'b0);
        tick("start_to_fetch");
        start = 1'b0;
    endtask

    task automatic fetch_step(input logic [3:0] ic, input logic v, input logic ie, output bit h);
        icode = ic; instr_valid = v; imem_error = ie;
        h = 1'b1;
        if (ie)            exp_stat = 3'd3;
        else if (!v)       exp_stat = 3'd4;
        else if (ic == 0)  exp_stat = 3'd2;
        else               h = 1'b0;
        push(h ? 7 : 2, 1'b0);
        tick("fetch");
        icode = 4'h0; instr_valid = 1'b1; imem_error = 1'b0;
    endtask

    task automatic body(input logic [3:0] ic, input int nwait, input logic derr, output bit h);
        bit is_mem;
        is_mem = (ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB);
        h = 1'b0;
        push(3, 1'b0);
        tick("decode_to_execute");
        push(4, is_mem);
        tick("execute_to_memory");
        if (!is_mem) begin
            mem_ready = 1'b1; dmem_error = 1'b1;
            push(5, 1'b0);
            tick("nonmem_ignores_ready");
        end else begin
            for (int w = 0; w < 64; w++) begin
                if (w < nwait) begin
                    mem_ready = 1'b0;
                    if (w == MEM_TIMEOUT - 1) begin
                        exp_stat = 3'd3;
                        push(7, 1'b0);
                        tick("mem_timeout");
                        h = 1'b1;
                        break;
                    end
                    push(4, 1'b1);
                    tick("mem_wait");
                end else begin
                    mem_ready = 1'b1; dmem_error = derr;
                    if (derr) begin
                        exp_stat = 3'd3;
                        push(7, 1'b0);
                        tick("dmem_fault");
                        h = 1'b1;
                    end else begin
                        push(5, 1'b0);
                        tick("mem_done");
                    end
                    break;
                end
            end
        end
        mem_ready = 1'b0; dmem_error = 1'b0;
        if (!h) begin
            push(6, 1'b0);
            tick("writeback");
            push(1, 1'b0);
            tick("pcupd_to_fetch");
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; icode = 4'h0; instr_valid = 1'b1;
        imem_error = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
        exp_stat = 3'd1;
        #12;
        push(0, 1'b0);
        check_now("reset_values");
        chk_cnt("reset_counters", 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(0, 1'b0);
            tick("idle_hold");
        end
        chk_cnt("idle_counters", 0, 0);

        begin_run();
        for (int k = 0; k < 3; k++) begin
            fetch_step(4'h6, 1'b1, 1'b0, halted);
            body(4'h6, 0, 1'b0, halted);
        end
        chk_cnt("three_opq", 18, 3);
        fetch_step(4'h0, 1'b1, 1'b0, halted);
        start = 1'b1;
        push(7, 1'b0);
        tick("halt_ignores_start");
        start = 1'b0;
        chk_cnt("after_hlt", 19, 3);

        do_reset("reset_after_hlt");
        begin_run();
        fetch_step(4'h5, 1'b1, 1'b0, halted);
        body(4'h5, 3, 1'b0, halted);
        chk_cnt("mem_wait_counts", 9, 1);

        do_reset("reset_before_ins");
        begin_run();
        fetch_step(4'h6, 1'b0, 1'b0, halted);
        push(7, 1'b0);
        tick("ins_halt_holds");

        do_reset("reset_before_imem");
        begin_run();
        fetch_step(4'h6, 1'b0, 1'b1, halted);
        push(7, 1'b0);
        tick("imem_halt_holds");

        do_reset("reset_before_dmem");
        begin_run();
        fetch_step(4'hA, 1'b1, 1'b0, halted);
        body(4'hA, 0, 1'b1, halted);
        push(7, 1'b0);
        tick("dmem_halt_holds");
        chk_cnt("dmem_not_retired", 4, 0);

        do_reset("reset_before_timeout");
        begin_run();
        fetch_step(4'h8, 1'b1, 1'b0, halted);
        body(4'h8, 100, 1'b0, halted);
        start = 1'b1;
        push(7, 1'b0);
        tick("timeout_ignores_start");
        start = 1'b0;
        chk_cnt("timeout_counts", 18, 0);

        do_reset("reset_before_async");
        begin_run();
        fetch_step(4'h6, 1'b1, 1'b0, halted);
        body(4'h6, 0, 1'b0, halted);
        fetch_step(4'h6, 1'b1, 1'b0, halted);
        push(3, 1'b0);
        tick("second_execute");
        do_reset("async_reset_midcycle");
        push(0, 1'b0);
        tick("idle_after_async");
        begin_run();
        chk_cnt("restart_counters", 0, 0);
        fetch_step(4'h1, 1'b1, 1'b0, halted);
        body(4'h1, 0, 1'b0, halted);
        chk_cnt("restart_nop", 6, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_stage_sequencer.md
# y86_stage_sequencer

Multi-cycle stage sequencer for the Y86-64 sequential processor. A state machine steps the fetch, decode, execute, memory, writeback and PC-update stages one per cycle, with a single stage enabled at a time. It holds the memory stage until the data memory acknowledges, and it raises the architectural status code on any fault or halt. It also keeps cycle and retired-instruction counters for the testbench and performance reporting.

## Interface
Parameters:
- CNT_W, 32, width of cycle_count and instr_count
- MEM_TIMEOUT, 15, maximum memory-stage wait cycles before an ADR fault (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin execution from IDLE
- icode  in  4  instruction code from fetch, valid in the FETCH cycle
- instr_valid  in  1  fetch decoded a legal instruction, valid in the FETCH cycle
- imem_error  in  1  fetch address out of range, valid in the FETCH cycle
- mem_ready  in  1  data memory access complete
- dmem_error  in  1  data memory address fault, qualified by mem_ready
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  out  1 each  stage enables, one-hot or all zero
- mem_req  out  1  data memory access request
- stat  out  3  status: AOK=1, HLT=2, ADR=3, INS=4
- busy  out  1  high in any state other than IDLE or HALT
- cycle_count  out  CNT_W  number of busy cycles
- instr_count  out  CNT_W  number of retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- All outputs are registered or decoded from state only (Moore); none depends combinationally on inputs.
- Reset values: state IDLE, all enables 0, mem_req 0, stat AOK (1), busy 0, both counters 0.
- IDLE: if start=1, go to FETCH; otherwise stay.
- FETCH (fetch_en=1): icode, instr_valid and imem_error are sampled at the clock edge, and icode is latched into icode_q. Checks are applied in priority order:
  - imem_error=1: stat becomes ADR, go to HALT.
  - instr_valid=0: stat becomes INS, go to HALT.
  - icode=0: stat becomes HLT, go to HALT.
  - Otherwise go to DECODE.
- DECODE, then EXECUTE: one cycle each with the matching enable high; unconditional advance.
- MEMORY (memory_en=1):
  - mem_req=1 only when icode_q is one of 4, 5, 8, 9, A, B (rmmovq, mrmovq, call, ret, pushq, popq).
  - Non-memory icode: one cycle, then WRITEBACK.
  - Memory icode: stay in MEMORY until mem_ready=1.
    - mem_ready=1 with dmem_error=1: stat becomes ADR, go to HALT.
    - mem_ready=1 with dmem_error=0: go to WRITEBACK.
  - A wait counter clears on entry to MEMORY. If it reaches MEM_TIMEOUT with no mem_ready, stat becomes ADR and the block goes to HALT.
- WRITEBACK, then PCUPD: one cycle each. In PCUPD, instr_count increments and the next state is FETCH.
- HALT: absorbing state. start is ignored, all enables are 0 and stat holds. Only rst_n exits HALT.
- A faulting instruction never asserts writeback_en or pc_en and is not counted.
- cycle_count increments on every cycle where busy=1. Both counters wrap modulo 2^CNT_W with no saturation.
- mem_ready or dmem_error arriving outside MEMORY, or while icode_q is a non-memory code, is ignored.

## Timing
- The first fetch_en occurs in the cycle after start is sampled high in IDLE.
- A non-memory instruction takes 6 cycles, FETCH through PCUPD. A memory instruction takes 6+N cycles, where N is the number of cycles mem_ready is low in MEMORY. mem_ready high in the first MEMORY cycle gives N=0.
- Back-to-back instructions: fetch_en rises in the cycle after pc_en, with no gap.
- mem_req rises with memory_en and falls in the cycle after mem_ready is sampled high.
- Transition into HALT: stat updates in the same cycle busy falls. Outputs on that edge are all enables 0 and mem_req 0.
- Reset mid-operation: assertion clears every output immediately, without waiting for a clock edge. After deassertion the block sits in IDLE and needs a new start.

## Test plan
- Reset/idle: hold rst_n=0, then release with start=0 for 10 cycles. Stat stays 1, all enables stay 0, both counters stay 0 and busy stays 0.
- Sequence: start, then 3 instructions with icode=6 (OPq), all valid. Fetch_en pulses at cycles 1, 7 and 13, and the stage enables are one-hot in F-D-E-M-W-P order. After 18 cycles instr_count=3 and cycle_count=18; on the fourth FETCH, icode=0 gives stat=2 and busy=0.
- Memory wait: icode=5, mem_ready low for 3 MEMORY cycles. mem_req is high for 4 cycles, the instruction takes 9 cycles, and instr_count=1.
- Faults:
  - instr_valid=0 in FETCH gives stat=4, with no decode_en.
  - imem_error=1 together with instr_valid=0 gives stat=3, because imem_error has priority.
  - icode=A with mem_ready=1 and dmem_error=1 gives stat=3, and writeback_en and pc_en are never asserted.
- Timeout: icode=8 with mem_ready held at 0 and MEM_TIMEOUT=15. The block enters HALT with stat=3 after 15 MEMORY cycles; a start pulse afterwards has no effect.
- Async reset: drop rst_n between clock edges while in the EXECUTE state of the second instruction. All outputs are at reset values before the next edge; after release and start, execution resumes from FETCH with the counters at 0.
